// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared widths, response entry layout and timer sizing for the sram-like responder.
package sram_like_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STRB_W = DEF_DATA_W / 8;
  function automatic int timer_w(input int lat);
    return $clog2(lat + 1);
  endfunction
  localparam int DEF_TIMER_W = timer_w(2);
  typedef struct packed {
    logic [DEF_DATA_W-1:0]  data;
    logic [DEF_TIMER_W-1:0] timer;
  } resp_entry_t;
endpackage

// File: rtl/sram_like_resp_fifo.sv
// sram_like_resp_fifo: in-order response queue whose entries age down to a ready-to-issue state.
module sram_like_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = 2,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              head_ready_o,
  output logic [DATA_W-1:0] head_data_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW = timer_w(LATENCY);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TW-1:0]     timer;
  } entry_t;
  entry_t                mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  assign full_o       = count_q[DEPTH_LOG2];
  assign empty_o      = count_q == '0;
  assign head_ready_o = !empty_o && mem_q[rd_ptr_q].timer == '0;
  assign head_data_o  = mem_q[rd_ptr_q].data;
  assign count_d      = count_q + (DEPTH_LOG2+1)'(push_i) - (DEPTH_LOG2+1)'(pop_i);
  // Free slots age as well; harmless because a push overwrites the timer.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      mem_q[i].timer <= mem_q[i].timer == '0 ? '0 : mem_q[i].timer - 1'b1;
    if (push_i) mem_q[wr_ptr_q] <= '{data: push_data_i, timer: TW'(LATENCY - 1)};
  end
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(push_i);
      rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(pop_i);
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: sram-like slave with word memory, bounded outstanding queue and
// programmable minimum response latency; stall inputs inject address/data back-pressure.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = 2,
  parameter int LATENCY    = 2,
  parameter int MEM_AW     = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                wr,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                stall_addr,
  input  logic                stall_data,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [DATA_W-1:0]   rdata
);
  localparam int SW = DATA_W / 8;
  logic [DATA_W-1:0] mem_q [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic              full, empty, head_ready, accept;
  logic [DATA_W-1:0] head_data;
  logic              unused_bits;
  assign idx         = addr[MEM_AW+1:2];
  assign addr_ok     = req && !full && !stall_addr && rst;
  assign accept      = req && addr_ok;
  assign data_ok     = head_ready && !stall_data;
  assign rdata       = data_ok ? head_data : '0;
  assign unused_bits = ^{addr[ADDR_W-1:MEM_AW+2], addr[1:0], empty};
  // Only one accept per cycle, so a read here already sees every earlier write.
  always_ff @(posedge clk) begin
    if (accept && wr)
      for (int b = 0; b < SW; b++)
        if (wstrb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
  end
  sram_like_resp_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .LATENCY   (LATENCY)
  ) u_fifo (
    .clk         (clk),
    .rst_ni      (rst),
    .push_i      (accept),
    .push_data_i (wr ? '0 : mem_q[idx]),
    .pop_i       (data_ok),
    .full_o      (full),
    .empty_o     (empty),
    .head_ready_o(head_ready),
    .head_data_o (head_data)
  );
endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Slave (responder) end of the sram-like interface that the IF/IW fetch path drives as master.
- Accepts requests with an addr_ok handshake and queues up to 2^DEPTH_LOG2 outstanding transactions.
- Returns one in-order data_ok/rdata response per transaction after a programmable minimum latency.
- Backed by an internal word-addressed memory. Used as a bench/SoC memory model and as a stall injector for exercising IW discard and flush handling.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- DEPTH_LOG2, 2, log2 of outstanding-queue depth (minimum 1)
- LATENCY, 2, minimum cycles from accept to data_ok (minimum 1)
- MEM_AW, 10, log2 of memory words

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- req  in  1  master request valid
- wr  in  1  1 = write, 0 = read
- wstrb  in  DATA_W/8  byte write enables (writes only)
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  write data
- stall_addr  in  1  forces addr_ok low
- stall_data  in  1  holds off data_ok
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  response valid this cycle
- rdata  out  DATA_W  read data (0 for write responses)

Behaviour:
- Accept condition: accept = req && addr_ok.
- addr_ok is combinational: req && !full && !stall_addr && rst. There is no bypass when full; a same-cycle pop does not free the slot for that cycle.
- Memory index: addr[MEM_AW+1:2]. Bits [1:0] and upper bits are ignored, so out-of-range addresses wrap modulo 2^MEM_AW words.
- Write on accept:
  - The memory word updates at that posedge, byte lanes per wstrb.
  - A response entry is queued with rdata=0.
- Read on accept:
  - The memory word is captured into the queue entry at accept.
  - The captured value already reflects every earlier-accepted write, which gives in-order read-after-write.
- Queue entry: {data, timer}.
  - timer loads LATENCY-1 at accept.
  - Each cycle, every valid entry's timer decrements, saturating at 0.
  - Timer width is clog2(LATENCY+1).
- Response:
  - data_ok = head valid && head timer==0 && !stall_data. Registered queue state only; no combinational path from req.
  - rdata = head data when data_ok, else 0.
  - Pop on data_ok. At most one response per cycle, strictly in accept order.
- Latency: an accept at cycle T gives its earliest data_ok at cycle T+LATENCY.
  - With req held high and no stalls, throughput is one transaction per cycle after the initial LATENCY.
- Occupancy:
  - count has width DEPTH_LOG2+1.
  - full = count==2^DEPTH_LOG2; empty = count==0.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap at 2^DEPTH_LOG2.
- stall_data only delays data_ok. Entries keep aging, and when the stall drops the queued responses issue back-to-back.
- Reset (asserted anytime, async):
  - Queue is emptied, pointers and count go to 0, data_ok=0, rdata=0.
  - Outstanding transactions are dropped; no data_ok appears after release until a new accept.
  - Memory contents are not reset.
- No flush input. Discarding responses is the master's job; the responder always answers every accepted request exactly once.

Decomposition:
- Package sram_like_pkg holds:
  - ADDR_W/DATA_W defaults
  - the strobe width constant
  - a resp_entry_t struct {data, timer}
  - a clog2-based timer-width function
- One sub-module, sram_like_resp_fifo: the parameterised in-order queue with per-entry aging timers, push/pop, and full/empty/head-ready outputs.
- The top level holds the memory array, the accept logic and the output muxing.

Test Plan:
1. Write 0xDEADBEEF to 0x10, wstrb=0xF, at T0; read 0x10 at T1 (LATENCY=2) -> write data_ok at T2 with rdata=0; read data_ok at T3 with rdata=0xDEADBEEF.
2. Byte write 0x00000055 to 0x10, wstrb=0x1; then read 0x10 -> rdata=0xDEADBE55. Read 0x1010 (MEM_AW=10 wrap) -> same 0xDEADBE55.
3. stall_data=1 with req held for reads of 0x0/0x4/0x8/0xC:
   - 4 accepts, then addr_ok=0 on the 5th (full).
   - Drop stall_data -> 4 data_ok in consecutive cycles in address order; addr_ok rises the cycle after the first pop.
4. Back-to-back reads of 8 addresses, no stalls, LATENCY=2 -> addr_ok high every cycle; data_ok high every cycle from T0+2 through T0+9.
5. stall_addr=1 for 3 cycles with req high -> addr_ok=0 and no accept; the queue is unchanged during the stall.
6. Assert rst with 3 reads outstanding -> data_ok and rdata are 0 immediately. After release, no data_ok until a new request; previously written memory still reads back correctly.
